// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side sequencer for the memory block.
// It accepts one read/write request at a time and turns it into an address
// phase, a data phase and, for reads, a latency wait. The read data is
// returned on a valid/ready response port.
//
// Handshake rule for both ports: a transfer happens on the rising clk edge
// where valid && ready are both 1. The response holds rsp_valid, rsp_wr and
// rsp_rdata stable until that edge. A request is accepted only in IDLE, so at
// most one transaction is outstanding.
//
// Every output is a register. Each state decides the outputs for the next state.
module mem_access_ctrl #(
   parameter int AW     = 8,
   parameter int DW     = 8,
   parameter int RD_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_wr,
   input  logic          req_sel,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rd_en,
   output logic          wr_en,
   output logic          addrreg_en,
   output logic          addrbuff_en,
   output logic          datareg_en,
   output logic          databuff_en,
   output logic [AW-1:0] addr_in,
   output logic [DW-1:0] data_in,
   input  logic [DW-1:0] data_out,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_wr,
   output logic [DW-1:0] rsp_rdata,
   output logic [15:0]   txn_count
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [3:0] LAT = 4'(RD_LAT);

   // The state register is visible at dut.state so that checkers can read it.
   logic [2:0]    state;
   logic          wr_q;
   logic          sel_q;
   logic [DW-1:0] wdata_q;
   logic [3:0]    cnt;

   // Sequencer: state, the latched request, the latency counter and every registered output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         wr_q        <= 1'b0;
         sel_q       <= 1'b0;
         wdata_q     <= '0;
         cnt         <= '0;
         req_ready   <= 1'b1;
         rd_en       <= 1'b0;
         wr_en       <= 1'b0;
         addrreg_en  <= 1'b0;
         addrbuff_en <= 1'b0;
         datareg_en  <= 1'b0;
         databuff_en <= 1'b0;
         addr_in     <= '0;
         data_in     <= '0;
         rsp_valid   <= 1'b0;
         rsp_wr      <= 1'b0;
         rsp_rdata   <= '0;
         txn_count   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  wr_q        <= req_wr;
                  sel_q       <= req_sel;
                  wdata_q     <= req_wdata;
                  req_ready   <= 1'b0;
                  rd_en       <= ~req_wr;
                  wr_en       <= req_wr;
                  addr_in     <= req_addr;
                  addrreg_en  <= ~req_sel;
                  addrbuff_en <= req_sel;
                  state       <= S_ADDR;
               end
            end
            S_ADDR: begin
               addrreg_en  <= 1'b0;
               addrbuff_en <= 1'b0;
               datareg_en  <= ~sel_q;
               databuff_en <= sel_q;
               data_in     <= wr_q ? wdata_q : '0;
               state       <= S_DATA;
            end
            S_DATA: begin
               datareg_en  <= 1'b0;
               databuff_en <= 1'b0;
               data_in     <= '0;
               if (wr_q || (LAT == 4'd0)) begin
                  // Writes finish here. A zero-latency read samples the memory now.
                  rd_en     <= 1'b0;
                  wr_en     <= 1'b0;
                  addr_in   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_wr    <= wr_q;
                  rsp_rdata <= wr_q ? '0 : data_out;
                  state     <= S_RESP;
               end else begin
                  cnt   <= LAT;
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rd_en     <= 1'b0;
                  addr_in   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_wr    <= 1'b0;
                  rsp_rdata <= data_out;
                  state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_wr    <= 1'b0;
                  rsp_rdata <= '0;
                  txn_count <= txn_count + 16'd1;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl. It applies table vectors, random vectors and
// hand-written corner sequences. Expected responses go to a scoreboard queue.
// A simple memory model drives data_out, and it returns valid data only in
// the cycle where the read should be captured.
module tb_mem_access_ctrl;

   localparam int AW     = 8;
   localparam int DW     = 8;
   localparam int RD_LAT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_wr = 1'b0;
   logic          req_sel = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rd_en, wr_en, addrreg_en, addrbuff_en, datareg_en, databuff_en;
   logic [AW-1:0] addr_in;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic          rsp_wr;
   logic [DW-1:0] rsp_rdata;
   logic [15:0]   txn_count;

   typedef struct {
      logic          wr;
      logic          sel;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      int            exp_lat;
   } vec_t;

   logic [DW:0] exp_q[$];
   logic [15:0] exp_cnt = '0;
   int          n_pass = 0;
   int          n_total = 0;
   int          cycle = 0;
   int          wait_cyc;

   mem_access_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
      .rd_en(rd_en), .wr_en(wr_en), .addrreg_en(addrreg_en),
      .addrbuff_en(addrbuff_en), .datareg_en(datareg_en),
      .databuff_en(databuff_en), .addr_in(addr_in), .data_in(data_in),
      .data_out(data_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .txn_count(txn_count)
   );

   // clock, cycle counter, watchdog
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;
   initial begin
      #300000;
      $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // Memory model: a read returns ~addr only in the RD_LAT-th wait cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) wait_cyc <= 0;
      else if (rd_en && (datareg_en || databuff_en)) wait_cyc <= 1;
      else if (rd_en && wait_cyc != 0) wait_cyc <= wait_cyc + 1;
      else wait_cyc <= 0;
   end
   assign data_out = (rd_en && wait_cyc == RD_LAT) ? ~addr_in : 8'hEE;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Response scoreboard and per-cycle invariants, sampled on the falling edge
   always @(negedge clk) begin
      if (!rst) begin
         chk("rd_wr_exclusive", {31'd0, rd_en & wr_en}, 32'd0);
         chk("strobes_onehot0",
             {31'd0, $onehot0({addrreg_en, addrbuff_en, datareg_en, databuff_en})}, 32'd1);
         if (rsp_valid)
            chk("resp_mem_quiet", {rd_en, wr_en, addrreg_en, addrbuff_en, datareg_en,
                databuff_en, addr_in, data_in}, 32'd0);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
               chk("rsp_data", {rsp_wr, rsp_rdata}, exp_q.pop_front());
            end
            exp_cnt = exp_cnt + 16'd1;
         end
      end
   end

   task automatic run_txn(input vec_t v, input bit hold);
      int n;
      req_wr = v.wr; req_sel = v.sel; req_addr = v.addr; req_wdata = v.wdata;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin step(); n++; end
      chk("req_accept", {31'd0, req_ready}, 32'd1);
      exp_q.push_back({v.wr, v.exp_rdata});
      step();
      req_valid = 1'b0;
      chk("addr_phase", {rd_en, wr_en, addrreg_en, addrbuff_en, datareg_en, databuff_en},
          {~v.wr, v.wr, ~v.sel, v.sel, 2'b00});
      chk("addr_phase_addr", addr_in, v.addr);
      chk("busy_ready", {31'd0, req_ready}, 32'd0);
      step();
      chk("data_phase", {rd_en, wr_en, addrreg_en, addrbuff_en, datareg_en, databuff_en},
          {~v.wr, v.wr, 2'b00, ~v.sel, v.sel});
      chk("data_phase_addr", addr_in, v.addr);
      chk("data_phase_wdata", data_in, v.wr ? v.wdata : 8'h00);
      n = 2;
      while (!rsp_valid && n < 40) begin step(); n++; end
      chk("rsp_latency", n, v.exp_lat);
      if (!hold) begin
         step();
         chk("req_ready_after", {31'd0, req_ready}, 32'd1);
         chk("txn_count", txn_count, exp_cnt);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic sel,
                               input logic [7:0] addr, input logic [7:0] wdata);
      vec_t v;
      v.wr = wr; v.sel = sel; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = wr ? 8'h00 : ~addr;
      v.exp_lat = wr ? 3 : 3 + RD_LAT;
      return v;
   endfunction

   vec_t vecs[6];
   vec_t b2b[3];
   vec_t v;

   initial begin
      int n, last;
      vecs[0] = mk(1'b1, 1'b0, 8'h55, 8'hAA);
      vecs[1] = mk(1'b0, 1'b1, 8'hF0, 8'h00);
      vecs[2] = mk(1'b0, 1'b0, 8'h00, 8'h33);
      vecs[3] = mk(1'b1, 1'b1, 8'hFF, 8'h00);
      vecs[4] = mk(1'b0, 1'b1, 8'hFF, 8'hC3);
      vecs[5] = mk(1'b1, 1'b0, 8'h01, 8'hFF);

      // reset state
      #12;
      chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_outputs", {rd_en, wr_en, addrreg_en, addrbuff_en, datareg_en, databuff_en,
          rsp_valid, rsp_wr, addr_in, data_in}, 32'd0);
      chk("reset_rdata_count", {rsp_rdata, txn_count}, 32'd0);
      step();
      rst = 1'b0;
      step();

      // table vectors
      for (int i = 0; i < 6; i++) run_txn(vecs[i], 1'b0);
      chk("rdata_buf_read", 32'h0F, vecs[1].exp_rdata);

      // random vectors
      for (int i = 0; i < 6; i++) begin
         v = mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         run_txn(v, 1'b0);
      end

      // response backpressure on a read that returns 0x5A
      rsp_ready = 1'b0;
      run_txn(mk(1'b0, 1'b0, 8'hA5, 8'h00), 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_rsp_rdata", rsp_rdata, 32'h5A);
         chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
      chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_txn_count", txn_count, exp_cnt);

      // reset during the wait state of a read
      req_wr = 1'b0; req_sel = 1'b1; req_addr = 8'h3C; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin step(); n++; end
      step();
      req_valid = 1'b0;
      step();
      step();
      chk("mid_wait_rd_en", {31'd0, rd_en}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      exp_q.delete();
      exp_cnt = '0;
      chk("rst_mem_outputs", {rd_en, wr_en, addrreg_en, addrbuff_en, datareg_en, databuff_en,
          addr_in, data_in}, 32'd0);
      chk("rst_rsp_count", {rsp_valid, txn_count}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      step();
      step();
      rst = 1'b0;
      step();
      step();
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);

      // back-to-back requests with req_valid held high
      b2b[0] = mk(1'b1, 1'b0, 8'h10, 8'h11);
      b2b[1] = mk(1'b0, 1'b1, 8'h20, 8'h00);
      b2b[2] = mk(1'b1, 1'b1, 8'h30, 8'h33);
      req_valid = 1'b1;
      last = 0;
      for (int k = 0; k < 3; k++) begin
         req_wr = b2b[k].wr; req_sel = b2b[k].sel;
         req_addr = b2b[k].addr; req_wdata = b2b[k].wdata;
         n = 0;
         while (!req_ready && n < 50) begin step(); n++; end
         chk("b2b_accept", {31'd0, req_ready}, 32'd1);
         if (k > 0) chk("b2b_spacing", cycle - last, b2b[k-1].exp_lat + 1);
         last = cycle;
         exp_q.push_back({b2b[k].wr, b2b[k].exp_rdata});
         step();
         chk("b2b_busy_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0;
      n = 0;
      while (!req_ready && n < 50) begin step(); n++; end
      chk("b2b_idle", {31'd0, req_ready}, 32'd1);
      chk("b2b_txn_count", txn_count, 32'd3);
      chk("b2b_txn_model", txn_count, exp_cnt);

      // counter wrap
      force dut.txn_count = 16'hFFFF;
      #1;
      release dut.txn_count;
      exp_cnt = 16'hFFFF;
      run_txn(mk(1'b1, 1'b1, 8'h77, 8'h88), 1'b0);
      chk("txn_wrap", txn_count, 32'd0);

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
